// File: rtl/window_gen_pkg.sv
// Shared types and constants for the 3x3 window generator.
package window_gen_pkg;

    localparam int unsigned KERNEL_SIZE = 3;
    localparam int unsigned DATA_SIZE   = 8;

    typedef logic [DATA_SIZE-1:0] pixel_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage, indexed by column.
// The read port shows the old entry at i_idx in the same cycle it is overwritten.
module line_buffer #(
    parameter int unsigned IMG_WIDTH = 8,
    parameter int unsigned DATA_SIZE = 8,
    localparam int unsigned IdxW     = $clog2(IMG_WIDTH)
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_we,
    input  logic [IdxW-1:0]      i_idx,
    input  logic [DATA_SIZE-1:0] i_wdata,
    output logic [DATA_SIZE-1:0] o_rdata
);

    logic [DATA_SIZE-1:0] mem_q [IMG_WIDTH];

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int i = 0; i < IMG_WIDTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (i_we) begin
            mem_q[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_idx];

endmodule

// File: rtl/window_gen_3x3.sv
// Raster-stream to 3x3 window generator with valid-only padding.
// Optional start-of-frame input and sticky framing error under `WINDOW_GEN_SOF_EN.
module window_gen_3x3 #(
    parameter int unsigned DATA_SIZE   = 8,
    parameter int unsigned IMG_WIDTH   = 8,
    parameter int unsigned IMG_HEIGHT  = 8,
    parameter int unsigned KERNEL_SIZE = 3
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_valid,
`ifdef WINDOW_GEN_SOF_EN
    input  logic                 i_sof,
    output logic                 o_sof_err,
`endif
    input  logic [DATA_SIZE-1:0] i_pixel,
    output logic                 o_valid,
    output logic [2:0][2:0][DATA_SIZE-1:0] o_window,
    output logic                 o_frame_done,
    output logic                 o_busy
);
    import window_gen_pkg::*;

    localparam int unsigned ColW = $clog2(IMG_WIDTH);
    localparam int unsigned RowW = $clog2(IMG_HEIGHT);
    localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);

    if (KERNEL_SIZE != 3) begin : g_kernel_check
        $error("window_gen_3x3: KERNEL_SIZE must be 3");
    end

    logic [ColW-1:0] col_q, col_d, col_cur;
    logic [RowW-1:0] row_q, row_d, row_cur;
    state_e          state_q, state_d;
    logic            run_en, col_last, frame_last, sof_restart;
    logic [DATA_SIZE-1:0] lb0_rd, lb1_rd;
    logic [2:0][2:0][DATA_SIZE-1:0] win_q, win_d;
    logic            valid_q, valid_d;
    logic            frame_done_q, frame_done_d;
    logic            busy_q, busy_d;

`ifdef WINDOW_GEN_SOF_EN
    logic sof_err_q, sof_err_d;
    logic cnt_zero;

    // An accepted start-of-frame pixel is always position (0,0).
    assign sof_restart = i_valid && i_sof;
    assign col_cur     = sof_restart ? '0 : col_q;
    assign row_cur     = sof_restart ? '0 : row_q;
    assign cnt_zero    = (col_q == '0) && (row_q == '0);
    assign sof_err_d   = sof_err_q || (i_valid && (i_sof != cnt_zero));
    assign o_sof_err   = sof_err_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            sof_err_q <= 1'b0;
        end else begin
            sof_err_q <= sof_err_d;
        end
    end
`else
    assign sof_restart = 1'b0;
    assign col_cur     = col_q;
    assign row_cur     = row_q;
`endif

    assign col_last   = (col_cur == ColLast);
    assign frame_last = col_last && (row_cur == RowLast);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (i_valid) begin
            if (col_last) begin
                col_d = '0;
                row_d = (row_cur == RowLast) ? '0 : row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
                row_d = row_cur;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_valid) begin
            unique case (state_q)
                FILL: if (col_last && row_cur == RowW'(1)) state_d = RUN;
                RUN:  if (frame_last || sof_restart) state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    // RUN coincides with row >= 2, so only the column needs checking here.
    always_comb begin
        run_en       = (state_q == RUN);
        valid_d      = i_valid && run_en && (col_cur >= ColW'(2));
        frame_done_d = i_valid && frame_last;
        busy_d       = (col_d != '0) || (row_d != '0);
    end

    line_buffer #(
        .IMG_WIDTH (IMG_WIDTH),
        .DATA_SIZE (DATA_SIZE)
    ) u_lb0 (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_we    (i_valid),
        .i_idx   (col_cur),
        .i_wdata (i_pixel),
        .o_rdata (lb0_rd)
    );

    line_buffer #(
        .IMG_WIDTH (IMG_WIDTH),
        .DATA_SIZE (DATA_SIZE)
    ) u_lb1 (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_we    (i_valid),
        .i_idx   (col_cur),
        .i_wdata (lb0_rd),
        .o_rdata (lb1_rd)
    );

    always_comb begin
        win_d = win_q;
        if (i_valid) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = i_pixel;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_window     = win_q;
    assign o_frame_done = frame_done_q;
    assign o_busy       = busy_q;

endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Upstream stage of the 3x3 kernel filter.
- Accepts a raster-order pixel stream, one pixel per accepted cycle, and buffers two image lines.
- Emits complete 3x3 neighbourhood windows in the filter's i_data[row][col] layout, with a valid strobe that drives the filter's i_valid.
- Uses valid-padding only: a window is emitted only when all nine pixels lie inside the frame.

Parameters:
- DATA_SIZE, 8, pixel width in bits.
- IMG_WIDTH, 8, pixels per line; must be at least 3.
- IMG_HEIGHT, 8, lines per frame; must be at least 3.
- KERNEL_SIZE, 3, window dimension; fixed at 3 (elaboration error if any other value).

Ports:
- i_clk  in  1  clock.
- i_nrst  in  1  asynchronous active-low reset.
- i_valid  in  1  i_pixel is valid this cycle; no backpressure, every valid pixel is accepted.
- i_pixel  in  DATA_SIZE  pixel, raster order, top-left first.
- o_valid  out  1  o_window holds a new complete window; 1-cycle pulse per window.
- o_window  out  DATA_SIZE x 3 x 3  window; [0][0] is top-left (oldest row, oldest column), [2][2] is bottom-right (newest pixel).
- o_frame_done  out  1  1-cycle pulse after the last pixel of a frame is accepted.
- o_busy  out  1  high while a frame is partially received (pixel count not 0).

Behaviour:
- Reset: i_nrst is asynchronous, active-low; clock is i_clk. All of the following clear to 0: col/row counters, state, both line buffers, window registers, o_valid, o_window, o_frame_done, o_busy.
- Counters:
  - col counts 0..IMG_WIDTH-1; row counts 0..IMG_HEIGHT-1.
  - Widths are $clog2 of each dimension.
  - Both advance only on accepted pixels.
  - col wraps to 0 and row increments; at the last pixel both wrap to 0.
- Line buffers:
  - lb0 holds the previous line and lb1 the line before it; each is an IMG_WIDTH-entry array indexed by col.
  - On an accepted pixel at col c: lb1[c] <= lb0[c], lb0[c] <= i_pixel.
- Window register:
  - On an accepted pixel, each row shifts left by one column.
  - The new right column is {lb1[c], lb0[c], i_pixel} for rows 0, 1 and 2 respectively.
  - o_window is this register.
- Output strobe:
  - o_valid <= i_valid && row>=2 && col>=2.
  - Latency: window visible with o_valid exactly 1 cycle after the completing pixel is accepted.
  - Windows at col 0/1 are shifted internally but never flagged.
- State machine:
  - FILL: row<2, no output.
  - RUN: row>=2, outputs enabled.
  - FILL->RUN on the pixel that wraps col at row 1.
  - RUN->FILL on the last pixel of the frame.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2), in raster order.
- o_frame_done: registered pulse, asserted in the same cycle as the o_valid of the last window.
- o_busy: o_busy <= (next pixel count != 0).
- i_valid gaps: all state holds, o_valid=0, o_window holds its last value.
- Back-to-back frames: the first pixel of the next frame is accepted in the cycle after the last pixel, with no bubble. Stale line-buffer data is overwritten before use, because row 0/1 windows are never flagged.
- Reset mid-frame: the partial frame is discarded and the next accepted pixel is treated as (0,0).
- Arithmetic: none on pixel data; pure storage, so no width growth.

Optional Feature:
- Macro: WINDOW_GEN_SOF_EN.
- With it defined, add port i_sof (in, 1), qualified by i_valid:
  - i_sof=1 on an accepted pixel forces that pixel to (0,0); counters restart from there and state goes to FILL.
  - If i_sof=1 arrives when the count is not 0 (early start), a sticky output o_sof_err (out, 1, reset 0) sets. It clears only on reset.
  - If i_sof is missing when the count is 0, the pixel is still treated as (0,0) and o_sof_err sets.
- Without it: no i_sof and no o_sof_err; framing is purely by count.

Decomposition:
- Package window_gen_pkg holds:
  - state enum typedef {FILL, RUN};
  - localparam KERNEL_SIZE=3;
  - pixel typedef logic [DATA_SIZE-1:0] (DATA_SIZE as a package default).
- One sub-module: line_buffer, a parameterised IMG_WIDTH x DATA_SIZE array with write index, write enable, and read-before-write output. It is instantiated twice (lb0, lb1).

Test Plan:
- 8x8 frame, pixel = row*8+col, continuous i_valid:
  - first o_valid 1 cycle after pixel 18 is accepted, with window {{0,1,2},{8,9,10},{16,17,18}};
  - 36 windows in total;
  - last window {{45,46,47},{53,54,55},{61,62,63}}, coincident with o_frame_done.
- Same frame with i_valid toggling 1,0,0,1 pseudo-randomly: identical 36 windows in the same order; o_valid is never high in gap cycles.
- Two frames back-to-back, second frame pixel = 100+row*8+col: second frame's first window is {{100,101,102},{108,109,110},{116,117,118}}, with no contamination from frame 1.
- Reset asserted after pixel 30, then a fresh 8x8 frame: no o_valid during reset; o_busy=0 after reset; the new frame produces the full 36 correct windows.
- o_busy/o_frame_done: o_busy rises 1 cycle after pixel 0 is accepted and falls 1 cycle after pixel 63 is accepted; o_frame_done pulses exactly once per frame.
- (WINDOW_GEN_SOF_EN) i_sof pulsed on pixel 20 of a frame: o_sof_err=1 and stays set; the pixel is treated as (0,0); the next 64 pixels yield 36 correct windows.
